uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver: takes the asynchronous serial line, synchronises it, and detects and validates each start bit at mid-bit. It then shifts in a configurable number of data bits LSB-first, optionally checks parity, and checks one or two stop bits. It sits between the board RX pin and any byte consumer, and delivers one-cycle `rx_valid` pulses with per-frame error flags.

## Interface
- `CLK_FREQ`, 50000000: system clock in Hz.
- `BAUD_RATE`, 9600: line rate in baud.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- Derived values: `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer division, must be ≥ 4) and `HALF_DIV = BAUD_DIV / 2`.

Ports:
- `clk`  in  1: single clock; every register is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rx`  in  1: serial line; idles high; asynchronous to `clk`.
- `rx_data`  out  DATA_BITS: last received data word; bit 0 is the first bit on the wire.
- `rx_valid`  out  1: one-cycle pulse when a frame completes.
- `parity_err`  out  1: parity mismatch in the last frame; constant 0 when `PARITY`=0.
- `frame_err`  out  1: at least one stop bit of the last frame sampled low.

## Operation
- **Input path:** a two-flop synchroniser feeds `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Baud counter:** `cnt`, width `$clog2(BAUD_DIV)`. It is cleared on every state change. A sample is taken when `cnt` reaches its terminal value, and `cnt` clears at that point.
- **State IDLE:**
  - While `rx_s`=0 and `armed`=1: go to START, clear `cnt`.
  - `armed` is set whenever `rx_s`=1 in IDLE.
  - `armed` is cleared on entry to IDLE after a frame error. This stops a held-low line (break) from being re-decoded as back-to-back frames.
- **State START:**
  - Terminal value is `HALF_DIV-1`.
  - Sample 0 → go to DATA with `bit_cnt`=0.
  - Sample 1 → false start: go to IDLE with no outputs changed.
- **State DATA:**
  - Terminal value is `BAUD_DIV-1`.
  - Each sample shifts into `shift_reg` from the MSB side: `{rx_s, shift_reg[DATA_BITS-1:1]}`.
  - After `DATA_BITS` samples: go to PARITY if `PARITY`≠0, else STOP.
- **State PARITY:**
  - Terminal value is `BAUD_DIV-1`.
  - Store `par_bad`:
    - even parity: `^{data, sample} != 0`
    - odd parity: `^{data, sample} != 1`
  - Then go to STOP.
- **State STOP:**
  - Terminal value is `BAUD_DIV-1` for each of the `STOP_BITS` samples.
  - Any 0 sample sets `stop_bad`.
  - On the final stop sample, in the same clock edge:
    - `rx_data` ← `shift_reg` with the sample applied;
    - `parity_err` ← `par_bad`;
    - `frame_err` ← `stop_bad` or the current sample = 0;
    - `rx_valid` ← 1;
    - go to IDLE (with `armed` ← 0 if a frame error occurred).
- **Output hold:** `rx_data`, `parity_err` and `frame_err` hold until the next completed frame. False starts never change them.
- **Errored frames:** data is still delivered; `rx_valid` pulses regardless of errors.

## Timing
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0;
  - state=IDLE, `armed`=1, synchroniser=11, `cnt`=0, `bit_cnt`=0.
- **Reset mid-frame:** the frame is abandoned immediately; no `rx_valid` is produced.
- **Input latency:** a pin edge reaches `rx_s` 2 cycles later.
- **Sample instants:** let t0 be the first cycle IDLE sees `rx_s`=0.
  - Start bit is sampled at t0+`HALF_DIV`.
  - Sample k (k=1 for the first data bit) is at t0+`HALF_DIV`+k·`BAUD_DIV`.
- **Frame length:** N = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` bits.
- **`rx_valid`:** high for exactly the one cycle after the last stop sample, i.e. t0+`HALF_DIV`+(N-1)·`BAUD_DIV`+1.
- **Back-to-back frames:** the next start edge may arrive ½ bit after the last stop sample. The receiver is in IDLE by then and must catch it.
- **Glitch rejection:** a low pulse shorter than `HALF_DIV` cycles at `rx_s` produces no `rx_valid`.

## Test plan
All scenarios use `CLK_FREQ`=1600000 and `BAUD_RATE`=100000, so `BAUD_DIV`=16 and `HALF_DIV`=8.

1. **8N1, frame 0xA5:** drive one frame → `rx_valid` pulses exactly once with `rx_data`=8'hA5, `parity_err`=0, `frame_err`=0. Pulse timing matches the formula above ±0 cycles.
2. **8E1, 0x3C with parity bit 1 (wrong):** → `rx_data`=8'h3C, `parity_err`=1. A following correct frame 0x3C with parity bit 0 → `parity_err`=0.
3. **7O2, 0x55 with second stop bit 0:** → `rx_data`=7'h55, `frame_err`=1. Then hold `rx` low for 40 bit times → no further `rx_valid` until `rx` returns high and a new frame is sent.
4. **False start:** 5-cycle low glitch on `rx` → no `rx_valid`; outputs keep their previous values. A valid 0x81 frame afterwards is received correctly.
5. **Back-to-back frames:** 0x00, 0xFF, 0x5A sent with no idle gap (8N1) → three `rx_valid` pulses, each delivering the matching value.
6. **Reset mid-frame:** assert `rst` during data bit 4 of a frame → all outputs read 0 during reset, no `rx_valid` for that frame. The next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, parity and stop bits.
// Start bit is validated at mid-bit; every later bit is sampled one bit period on.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        cnt, cnt_n, term;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n, data_n;
  logic                 par_bad, par_bad_n, stop_bad, stop_bad_n;
  logic                 armed, armed_n;
  logic                 valid_n, perr_n, ferr_n;
  logic                 tick;

  assign rx_s = sync[1];
  assign term = (state == START) ? CW'(HALF_DIV - 1) : CW'(BAUD_DIV - 1);
  assign tick = (cnt == term);

  always_comb begin
    state_n    = state;
    cnt_n      = tick ? '0 : cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    par_bad_n  = par_bad;
    stop_bad_n = stop_bad;
    armed_n    = armed;
    data_n     = rx_data;
    valid_n    = 1'b0;
    perr_n     = parity_err;
    ferr_n     = frame_err;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_s)       armed_n = 1'b1;
        else if (armed) state_n = START;
      end
      START: if (tick) begin
        if (!rx_s) begin
          state_n    = DATA;
          bit_cnt_n  = '0;
          par_bad_n  = 1'b0;
          stop_bad_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: if (tick) begin
        shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
        if (bit_cnt == BW'(DATA_BITS - 1)) begin
          state_n   = (PARITY != 0) ? PAR : STOP;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PAR: if (tick) begin
        par_bad_n = (PARITY == 2) ? (^{shift_reg, rx_s}) : ~(^{shift_reg, rx_s});
        state_n   = STOP;
      end
      STOP: if (tick) begin
        if (bit_cnt == BW'(STOP_BITS - 1)) begin
          data_n  = shift_reg;
          perr_n  = (PARITY != 0) && par_bad;
          ferr_n  = stop_bad | ~rx_s;
          valid_n = 1'b1;
          // a line held low must return high before the next start is accepted
          armed_n = ~(stop_bad | ~rx_s);
          state_n = IDLE;
        end else begin
          stop_bad_n = stop_bad | ~rx_s;
          bit_cnt_n  = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= 2'b11;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      armed      <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sync       <= {sync[0], rx};
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      par_bad    <= par_bad_n;
      stop_bad   <= stop_bad_n;
      armed      <= armed_n;
      rx_data    <= data_n;
      rx_valid   <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

endmodule
